mem_port_arbiter: RTL

- Shares the single cache/memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined CPU.
- Selects one requester per transaction and drives the memory-side handshake with variable latency.
- Returns read data and a one-cycle ack to the winner.
- Produces stall indications that the pipeline Controller folds into pc_write and pipereg_we.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/memory handshake bundle shared by the IF/MEM port arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Optional grant/wait counters are enabled with ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] if_grants,
    output logic [31:0] dm_grants,
    output logic [31:0] wait_cycles
`endif
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             cs_q, cs_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             if_ack_q, if_ack_d;
    logic             dm_ack_q, dm_ack_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             err_q, err_d;
    logic [31:0]      rsp;
    logic             grant_dm;
    logic             any_req;
    logic             stall_if, stall_mem;

    // Data wins ties until it has starved a pending fetch MAX_D_STREAK times.
    assign any_req  = bus.if_req | bus.dm_req;
    assign grant_dm = bus.dm_req & ~(bus.if_req & (streak_q == STREAK_MAX));
    assign rsp      = bus.mem_ack ? bus.mem_rdata : NOP;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        streak_d   = streak_q;
        tcnt_d     = tcnt_q;
        cs_d       = cs_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    cs_d    = 1'b1;
                    win_d   = grant_dm;
                    if (grant_dm) begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                        if (!bus.if_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + 1'b1;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            BUSY: begin
                tcnt_d = tcnt_q + 1'b1;
                if (bus.mem_ack || tcnt_q == TO_LAST) begin
                    state_d = RESP;
                    cs_d    = 1'b0;
                    err_d   = err_q | ~bus.mem_ack;
                    if (win_q) begin
                        dm_ack_d = 1'b1;
                        // A completed store keeps the previous load data.
                        if (!we_q || !bus.mem_ack)
                            dm_rdata_d = rsp;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rsp;
                    end
                end
            end
            RESP: begin
                tcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            streak_q   <= '0;
            tcnt_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            streak_q   <= streak_d;
            tcnt_q     <= tcnt_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign stall_if  = bus.if_req & ~if_ack_q;
    assign stall_mem = bus.dm_req & ~dm_ack_q;

    assign bus.stall_if  = stall_if;
    assign bus.stall_mem = stall_mem;
    assign bus.mem_cs    = cs_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;

`ifdef ARB_PERF_CNT_EN
    logic grant_ev;

    assign grant_ev = (state_q == IDLE) & any_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_grants   <= '0;
            dm_grants   <= '0;
            wait_cycles <= '0;
        end else begin
            if (grant_ev && grant_dm)
                dm_grants <= dm_grants + 32'd1;
            if (grant_ev && !grant_dm)
                if_grants <= if_grants + 32'd1;
            if (stall_if || stall_mem)
                wait_cycles <= wait_cycles + 32'd1;
        end
    end
`endif
endmodule
